// File: rtl/ef_spi_xfer_ctrl_if.sv
// Host-side handshake bundle for the SPI transfer controller: command, TX and RX
// streams plus transfer status. All three streams move a word on a clock edge
// where valid and ready are both high; valid is never withdrawn for ready.
interface ef_spi_xfer_ctrl_if #(
  parameter int LW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          cmd_rx;
  logic          abort;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          busy;
  logic          xfer_done;
  logic          aborted;

  modport slave (
    input  cmd_valid, cmd_len, cmd_rx, abort, tx_valid, tx_data, rx_ready,
    output cmd_ready, tx_ready, rx_valid, rx_data, busy, xfer_done, aborted
  );

  modport master (
    output cmd_valid, cmd_len, cmd_rx, abort, tx_valid, tx_data, rx_ready,
    input  cmd_ready, tx_ready, rx_valid, rx_data, busy, xfer_done, aborted
  );
endinterface

// File: rtl/ef_spi_xfer_ctrl.sv
// Sequences one SPI transfer of N bytes: streams TX bytes into the engine FIFO,
// counts byte-done edges, handles abort, and holds slave select off for a guard time.
module ef_spi_xfer_ctrl #(
  parameter int LW    = 8,
  parameter int GUARD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ef_spi_xfer_ctrl_if.slave host,
  output logic              spi_wr,
  output logic [7:0]        spi_datai,
  input  logic              spi_tx_full,
  output logic              spi_tx_flush,
  output logic              spi_rd,
  input  logic [7:0]        spi_datao,
  input  logic              spi_rx_empty,
  output logic              spi_rx_en,
  output logic              spi_rx_flush,
  input  logic              spi_done,
  input  logic              spi_busy,
  output logic              spi_ss,
  output logic [2:0]        state_dbg
);
  localparam int CW = LW + 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_STOP  = 3'd4,
    S_GUARD = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, p_q, d_q;
  logic [GW-1:0] g_q;
  logic          rx_en_q, done_q;
  logic          in_xfer, abort_hit, done_rise, cmd_fire, last_push, drain_ok, guard_end;

  // Counters are one bit wider than cmd_len so N = 2^LW fits without wrapping.
  assign in_xfer   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign abort_hit = host.abort && in_xfer;
  assign done_rise = spi_done && !done_q;
  assign cmd_fire  = host.cmd_valid && (state_q == S_IDLE);
  assign last_push = spi_wr && ((p_q + CW'(1)) == n_q);
  assign drain_ok  = (d_q == n_q) && !spi_busy;
  assign guard_end = (g_q == GW'(GUARD - 1));
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = S_SETUP;
      S_SETUP: state_d = S_RUN;
      S_RUN: begin
        if (abort_hit)      state_d = S_STOP;
        else if (last_push) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_hit)     state_d = S_STOP;
        else if (drain_ok) state_d = S_GUARD;
      end
      S_STOP:  if (!spi_busy) state_d = S_GUARD;
      S_GUARD: if (guard_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abort masks tx_ready so a byte offered in the abort cycle is neither pushed nor counted.
  always_comb begin
    host.cmd_ready = (state_q == S_IDLE);
    spi_ss         = (state_q == S_SETUP) || in_xfer || (state_q == S_STOP);
    host.busy      = spi_ss;
    host.tx_ready  = (state_q == S_RUN) && !spi_tx_full && (p_q < n_q) && !host.abort;
    spi_wr         = host.tx_valid && host.tx_ready;
    spi_datai      = host.tx_data;
    spi_tx_flush   = (state_q == S_SETUP) || abort_hit;
    spi_rx_flush   = (state_q == S_SETUP) && rx_en_q;
    spi_rx_en      = in_xfer && rx_en_q;
    host.xfer_done = (state_q == S_DRAIN) && !host.abort && drain_ok;
    host.aborted   = (state_q == S_STOP) && !spi_busy;
    host.rx_valid  = !spi_rx_empty;
    host.rx_data   = spi_datao;
    spi_rd         = host.rx_valid && host.rx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      p_q     <= '0;
      d_q     <= '0;
      g_q     <= '0;
      rx_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= spi_done;
      if (cmd_fire) begin
        n_q     <= {1'b0, host.cmd_len} + CW'(1);
        rx_en_q <= host.cmd_rx;
      end
      if (state_q == S_SETUP) begin
        p_q <= '0;
        d_q <= '0;
      end else begin
        if (spi_wr)               p_q <= p_q + CW'(1);
        if (in_xfer && done_rise) d_q <= d_q + CW'(1);
      end
      g_q <= (state_q == S_GUARD) ? g_q + GW'(1) : '0;
    end
  end
endmodule
